golden_nonce_packer: RTL and testbench

//  Collects golden nonces found by the SHA-256 miner core and packs them into DLEN-byte result frames for the MIPI TX stage.

---
 rtl/golden_nonce_pkg.sv | 28 ++
 rtl/nonce_fifo.sv | 54 +++++
 rtl/golden_nonce_packer.sv | 183 ++++++++++++++++++
 tb/tb_golden_nonce_packer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/golden_nonce_pkg.sv
// Shared constants, frame layout offsets and FSM state type for the golden nonce packer.
package golden_nonce_pkg;

  localparam int unsigned EntryW     = 40;
  localparam int unsigned HdrMagicOff = 0;
  localparam int unsigned HdrCountOff = 4;
  localparam int unsigned HdrSeqOff   = 5;
  localparam int unsigned HdrOvfOff   = 6;
  localparam int unsigned EntryOff    = 8;
  localparam int unsigned EntryBytes  = 5;

  localparam logic [31:0] MagicDefault = 32'hA5C3_0001;

  typedef enum logic [2:0] {
    StIdle,
    StBatch,
    StFill,
    StLaunch,
    StWaitAck,
    StWaitDone
  } state_e;

  // Number of 5-byte entries that fit after the 8-byte header.
  function automatic int unsigned max_entries(input int unsigned dlen);
    return (dlen - EntryOff) / EntryBytes;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module nonce_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Aw    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      level_o
);

  localparam int unsigned Depth = 2 ** Aw;

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Aw:0]      level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  // Level can only reach Depth, so its MSB alone marks full.
  assign full_o  = level_q[Aw];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/golden_nonce_packer.sv
// Queues golden nonces and packs them into fixed-length result frames, launching each
// frame against the MIPI transmitter busy handshake.
module golden_nonce_packer
  import golden_nonce_pkg::*;
#(
  parameter int unsigned DLEN         = 64,
  parameter int unsigned FIFO_AW      = 3,
  parameter int unsigned BATCH_CYCLES = 1024,
  parameter int unsigned ACK_TIMEOUT  = 4096,
  parameter logic [31:0] MAGIC        = MagicDefault
) (
  input  logic              hash_clk,
  input  logic              reset,
  input  logic              nonce_valid,
  input  logic [31:0]       nonce,
  input  logic [7:0]        job_id,
  input  logic              tx_busy,
  output logic [DLEN*8-1:0] pix_gen_data,
  output logic              data_available,
  output logic              write_enable,
  output logic [FIFO_AW:0]  fifo_level,
  output logic [15:0]       overflow_cnt,
  output logic [7:0]        frame_seq
);

  localparam int unsigned MaxN     = max_entries(DLEN);
  localparam int unsigned CntW     = $clog2(MaxN + 1);
  localparam int unsigned LvlW     = FIFO_AW + 1;
  localparam int unsigned TimerMax = (BATCH_CYCLES > ACK_TIMEOUT) ? BATCH_CYCLES : ACK_TIMEOUT;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  localparam logic [TimerW-1:0] BatchLast = TimerW'((BATCH_CYCLES == 0) ? 0 : BATCH_CYCLES - 1);
  localparam logic [TimerW-1:0] AckLast   = TimerW'(ACK_TIMEOUT - 1);
  localparam logic [CntW-1:0]   MaxNCnt   = CntW'(MaxN);
  localparam logic [LvlW-1:0]   LvlOne    = LvlW'(1);

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DLEN*8-1:0]   frame_q, frame_d;
  logic                avail_q, avail_d;
  logic [7:0]          seq_q, seq_d;
  logic [7:0]          frame_seq_q, frame_seq_d;
  logic [15:0]         ovf_q, ovf_d;

  logic                fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0]   fifo_rdata;
  logic                batch_go, fill_done;

  nonce_fifo #(
    .Width (EntryW),
    .Aw    (FIFO_AW)
  ) u_fifo (
    .clk_i   (hash_clk),
    .rst_i   (reset),
    .push_i  (nonce_valid),
    .wdata_i ({job_id, nonce}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign batch_go = (BATCH_CYCLES == 0) || (32'(fifo_level) >= MaxN) || (timer_q == BatchLast);

  // Dropped entries: only a push into a full FIFO that is not being drained this cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (nonce_valid && fifo_full && !fifo_pop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    avail_d      = avail_q;
    seq_d        = seq_q;
    frame_seq_d  = frame_seq_q;
    fifo_pop     = 1'b0;
    fill_done    = 1'b0;
    write_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StBatch;
          timer_d = '0;
        end
      end
      StBatch: begin
        if (batch_go) begin
          // Busy transmitter: hold here with the timer parked at its trigger value.
          if (!tx_busy) begin
            state_d = StFill;
            frame_d = '0;
            cnt_d   = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StFill: begin
        fifo_pop = !fifo_empty;
        if (fifo_pop) begin
          cnt_d = cnt_q + 1'b1;
          for (int unsigned i = 0; i < MaxN; i++) begin
            if (cnt_q == CntW'(i)) begin
              frame_d[(EntryOff + EntryBytes * i) * 8 +: EntryW] =
                  {fifo_rdata[31:0], fifo_rdata[39:32]};
            end
          end
        end
        // Stop when the frame is full or this pop drains the FIFO with nothing arriving.
        fill_done = !fifo_pop || (cnt_d == MaxNCnt) || ((fifo_level == LvlOne) && !nonce_valid);
        if (fill_done) begin
          frame_d[HdrMagicOff * 8 +: 32] = MAGIC;
          frame_d[HdrCountOff * 8 +: 8]  = 8'(cnt_d);
          frame_d[HdrSeqOff * 8 +: 8]    = seq_q;
          frame_d[HdrOvfOff * 8 +: 16]   = ovf_q;
          avail_d = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        write_enable = 1'b1;
        timer_d      = '0;
        state_d      = StWaitAck;
      end
      StWaitAck: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (timer_q == AckLast) begin
          state_d = StIdle;
          avail_d = 1'b0;
          seq_d   = seq_q + 8'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d     = StIdle;
          avail_d     = 1'b0;
          frame_seq_d = seq_q;
          seq_d       = seq_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      avail_q     <= 1'b0;
      seq_q       <= '0;
      frame_seq_q <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      avail_q     <= avail_d;
      seq_q       <= seq_d;
      frame_seq_q <= frame_seq_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pix_gen_data   = frame_q;
  assign data_available = avail_q;
  assign overflow_cnt   = ovf_q;
  assign frame_seq      = frame_seq_q;

endmodule

// File: tb/tb_golden_nonce_packer.sv
// Directed bench: dut_a launches immediately (BATCH_CYCLES=0, 8-deep FIFO);
// dut_b batches (BATCH_CYCLES=1024, 16-deep FIFO).
module tb_golden_nonce_packer;

  logic         clk = 1'b0;
  logic         rst, nv, busy, sel;
  logic [31:0]  nonce_s;
  logic [7:0]   job_s;
  logic         nv_a, nv_b;

  logic [511:0] pix_a, pix_b, pix_m;
  logic         da_a, da_b, da_m, we_a, we_b, we_m;
  logic [3:0]   lvl_a;
  logic [4:0]   lvl_b, lvl_m;
  logic [15:0]  ovf_a, ovf_b, ovf_m;
  logic [7:0]   fseq_a, fseq_b, fseq_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign nv_a   = nv && !sel;
  assign nv_b   = nv && sel;
  assign pix_m  = sel ? pix_b : pix_a;
  assign da_m   = sel ? da_b : da_a;
  assign we_m   = sel ? we_b : we_a;
  assign lvl_m  = sel ? lvl_b : {1'b0, lvl_a};
  assign ovf_m  = sel ? ovf_b : ovf_a;
  assign fseq_m = sel ? fseq_b : fseq_a;

  golden_nonce_packer #(
    .DLEN(64), .FIFO_AW(3), .BATCH_CYCLES(0), .ACK_TIMEOUT(4096), .MAGIC(32'hA5C3_0001)
  ) dut_a (
    .hash_clk(clk), .reset(rst), .nonce_valid(nv_a), .nonce(nonce_s), .job_id(job_s),
    .tx_busy(busy), .pix_gen_data(pix_a), .data_available(da_a), .write_enable(we_a),
    .fifo_level(lvl_a), .overflow_cnt(ovf_a), .frame_seq(fseq_a)
  );

  golden_nonce_packer #(
    .DLEN(64), .FIFO_AW(4), .BATCH_CYCLES(1024), .ACK_TIMEOUT(4096), .MAGIC(32'hA5C3_0001)
  ) dut_b (
    .hash_clk(clk), .reset(rst), .nonce_valid(nv_b), .nonce(nonce_s), .job_id(job_s),
    .tx_busy(busy), .pix_gen_data(pix_b), .data_available(da_b), .write_enable(we_b),
    .fifo_level(lvl_b), .overflow_cnt(ovf_b), .frame_seq(fseq_b)
  );

  typedef struct packed {
    logic [31:0] nonce;
    logic [7:0]  job;
    logic [63:0] hdr;
    logic [39:0] ent;
    logic [7:0]  seq;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] ent(input int i);
    return pix_m[64 + 40 * i +: 40];
  endfunction

  task automatic push(input logic [31:0] n, input logic [7:0] j);
    nonce_s = n;
    job_s   = j;
    nv      = 1'b1;
    @(posedge clk);
    #1;
    nv = 1'b0;
  endtask

  // Returns at the negedge where write_enable is seen; n counts cycles from the call.
  task automatic wait_we(input int limit, output int n);
    n = 1;
    @(negedge clk);
    while (we_m !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_frame(input string tag, input logic [63:0] hdr, input int nent);
    chk({tag, " header"}, pix_m[63:0], hdr);
    chk({tag, " tail zero"}, |(pix_m >> ((8 + 5 * nent) * 8)), 0);
    chk({tag, " avail at launch"}, da_m, 1);
  endtask

  task automatic handshake(input string tag, input logic [7:0] exp_seq);
    busy = 1'b1;
    @(negedge clk);
    chk({tag, " we one-shot"}, we_m, 0);
    chk({tag, " avail held"}, da_m, 1);
    @(negedge clk);
    busy = 1'b0;
    @(negedge clk);
    chk({tag, " avail drop"}, da_m, 0);
    chk({tag, " frame_seq"}, fseq_m, exp_seq);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " pix"}, |pix_m, 0);
    chk({tag, " avail"}, da_m, 0);
    chk({tag, " we"}, we_m, 0);
    chk({tag, " level"}, lvl_m, 0);
    chk({tag, " ovf"}, ovf_m, 0);
    chk({tag, " seq"}, fseq_m, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{32'hDEADBEEF, 8'h07, 64'h0000_0001_A5C3_0001, 40'hDE_AD_BE_EF_07, 8'd0};
    vecs[1] = '{32'h12345678, 8'hA5, 64'h0000_0101_A5C3_0001, 40'h12_34_56_78_A5, 8'd1};
    vecs[2] = '{32'hFFFFFFFF, 8'hFF, 64'h0000_0201_A5C3_0001, 40'hFF_FF_FF_FF_FF, 8'd2};
    vecs[3] = '{32'h00000000, 8'h3C, 64'h0000_0301_A5C3_0001, 40'h00_00_00_00_3C, 8'd3};

    rst = 1'b1; nv = 1'b0; busy = 1'b0; sel = 1'b0; nonce_s = '0; job_s = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset a");
    sel = 1'b1;
    #1;
    chk_zero("reset b");
    sel = 1'b0;
    #1;
    rst = 1'b0;

    // Single-nonce frames with immediate launch.
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].nonce, vecs[i].job);
      wait_we(20, n);
      chk("single latency", n, 4);
      chk_frame("single", vecs[i].hdr, 1);
      chk("single entry", ent(0), vecs[i].ent);
      handshake("single", vecs[i].seq);
    end

    // Overflow while the transmitter is busy.
    busy = 1'b1;
    for (int k = 0; k < 12; k++) push(32'h1000_0000 + k, 8'h10 + 8'(k));
    @(negedge clk);
    chk("ovf level", lvl_m, 8);
    chk("ovf count", ovf_m, 4);
    busy = 1'b0;
    wait_we(30, n);
    chk("ovf launched", we_m, 1);
    chk_frame("ovf", 64'h0004_0408_A5C3_0001, 8);
    for (int k = 0; k < 8; k++) chk("ovf entry", ent(k), {32'h1000_0000 + k, 8'h10 + 8'(k)});
    handshake("ovf", 8'd4);

    // Push into a full FIFO on the first FILL pop.
    busy = 1'b1;
    for (int k = 0; k < 8; k++) push(32'h2000_0000 + k, 8'h20 + 8'(k));
    @(negedge clk);
    chk("full level", lvl_m, 8);
    busy = 1'b0;
    @(posedge clk);
    #1;
    push(32'hCAFEF00D, 8'h99);
    @(negedge clk);
    chk("full push kept level", lvl_m, 8);
    chk("full push ovf", ovf_m, 4);
    wait_we(30, n);
    chk_frame("full", 64'h0004_0509_A5C3_0001, 9);
    chk("full entry0", ent(0), 40'h20_00_00_00_20);
    chk("full entry8", ent(8), 40'hCA_FE_F0_0D_99);
    handshake("full", 8'd5);

    // Acknowledge timeout: busy never rises.
    push(32'h0BADCAFE, 8'h42);
    wait_we(20, n);
    chk_frame("tmo", 64'h0004_0601_A5C3_0001, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (da_m && n < 5000);
    chk("tmo avail cycles", n, 4097);
    chk("tmo frame_seq", fseq_m, 5);

    // Frame after timeout carries the advanced seq; reset it while in WAIT_DONE.
    push(32'h55AA55AA, 8'h5A);
    wait_we(20, n);
    chk("post-tmo latency", n, 4);
    chk_frame("post-tmo", 64'h0004_0701_A5C3_0001, 1);
    busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push(32'h1111_1111, 8'h01);
    push(32'h2222_2222, 8'h02);
    @(negedge clk);
    chk("wait_done level", lvl_m, 2);
    chk("wait_done avail", da_m, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("reset in wait_done");
    rst = 1'b0;
    busy = 1'b0;
    push(32'hDEADBEEF, 8'h07);
    wait_we(20, n);
    chk("post-reset latency", n, 4);
    chk_frame("post-reset", 64'h0000_0001_A5C3_0001, 1);
    chk("post-reset entry", ent(0), 40'hDE_AD_BE_EF_07);
    handshake("post-reset", 8'd0);

    // Batching instance: timer-driven launch, then level-driven launch.
    sel = 1'b1;
    #1;
    push(32'h0000_0ABC, 8'hE1);
    wait_we(1200, n);
    chk("batch timer latency", n, 1027);
    chk_frame("batch timer", 64'h0000_0001_A5C3_0001, 1);
    chk("batch timer entry", ent(0), 40'h00_00_0A_BC_E1);
    handshake("batch timer", 8'd0);
    for (int k = 0; k < 11; k++) push(32'h3000_0000 + k, 8'h30 + 8'(k));
    wait_we(200, n);
    chk("batch full latency", n, 13);
    chk_frame("batch full", 64'h0000_010B_A5C3_0001, 11);
    for (int k = 0; k < 11; k++) chk("batch entry", ent(k), {32'h3000_0000 + k, 8'h30 + 8'(k)});
    handshake("batch full", 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
